// File: rtl/digit_scan_pkg.sv
// Shared constants and types for the multiplexed 4-digit BCD scanner.
package digit_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_MAX    = 9;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

endpackage

// File: rtl/digit_scan_driver.sv
// Time-multiplexed 4-digit BCD scanner with blanking gaps, frame-atomic
// value commit, leading-zero suppression and invalid-nibble masking.
module digit_scan_driver
    import digit_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    output logic [3:0]  value_to_display,
    output logic [3:0]  digit_sel_n,
    output logic        frame_start
);

    localparam int MAXD = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYCLES - 1);

    scan_state_t r_state;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_pending;
    logic [15:0]   r_display;
    logic [3:0]    r_sel_n;
    logic [3:0]    r_val;
    logic          r_frame;

    logic [3:0]  w_shamt;
    logic [3:0]  w_nib;
    logic [15:0] w_upper;
    logic        w_bad;
    logic        w_lz;

    assign w_shamt = {r_idx, 2'b00};
    assign w_nib   = r_display[w_shamt +: 4];
    assign w_upper = r_display >> w_shamt;
    assign w_bad   = (w_nib > 4'(BCD_MAX));
    assign w_lz    = blank_lz && (r_idx != 2'd0) && (w_upper == 16'd0);

    // Display register only changes when digit 0 is entered, so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_GAP;
            r_idx     <= 2'd3;
            r_cnt     <= '0;
            r_pending <= 16'd0;
            r_display <= 16'd0;
        end else begin
            if (load) r_pending <= bcd_in;
            unique case (r_state)
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= ST_SHOW;
                        r_cnt   <= '0;
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd3)
                            r_display <= load ? bcd_in : r_pending;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_GAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_n <= 4'b1111;
            r_val   <= 4'd0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= (r_state == ST_SHOW) && (r_idx == 2'd0)
                       && (r_cnt == '0);
            if (r_state == ST_SHOW) begin
                r_sel_n <= (w_bad || w_lz) ? 4'b1111 : ~(4'b0001 << r_idx);
                r_val   <= w_bad ? 4'd0 : w_nib;
            end else begin
                r_sel_n <= 4'b1111;
            end
        end
    end

    assign digit_sel_n      = r_sel_n;
    assign value_to_display = r_val;
    assign frame_start      = r_frame;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Randomized bench for digit_scan_driver against a timeline-based reference.
module tb_digit_scan_driver;

    localparam int S  = 4;
    localparam int B  = 2;
    localparam int P  = S + B;
    localparam int FR = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'd0;
    logic        blank_lz = 1'b0;
    logic [3:0]  value_to_display;
    logic [3:0]  digit_sel_n;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    int          e;
    int          m_dig;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    logic [3:0]  m_val;
    logic [3:0]  exp_sel;
    logic        exp_fs;

    digit_scan_driver #(.SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load             (load),
        .bcd_in           (bcd_in),
        .blank_lz         (blank_lz),
        .value_to_display (value_to_display),
        .digit_sel_n      (digit_sel_n),
        .frame_start      (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t e=%0d got=%h exp=%h",
                     tag, $time, e, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference timeline, compare.
    task automatic step(input logic ld, input logic [15:0] v,
                        input logic blz);
        int m, nib, hi, p;
        load = ld;
        bcd_in = v;
        blank_lz = blz;
        @(posedge clk);
        e++;
        m = e - 1 - B;
        exp_sel = 4'b1111;
        exp_fs = 1'b0;
        m_dig = -1;
        if (m >= 0 && (m % P) < S) begin
            m_dig = (m / P) % 4;
            p = 1 << (4 * m_dig);
            hi = int'(m_disp) / p;
            nib = hi % 16;
            if (nib > 9) begin
                m_val = 4'd0;
            end else begin
                m_val = 4'(nib);
                if (!(blz && m_dig > 0 && hi == 0))
                    exp_sel = ~(4'b0001 << m_dig);
            end
            exp_fs = ((m % FR) == 0);
        end
        if (e >= B && ((e - B) % FR) == 0)
            m_disp = ld ? v : m_pend;
        if (ld) m_pend = v;
        @(negedge clk);
        chk("sel", 16'(digit_sel_n), 16'(exp_sel));
        chk("val", 16'(value_to_display), 16'(m_val));
        chk("frame", 16'(frame_start), 16'(exp_fs));
        load = 1'b0;
    endtask

    task automatic do_reset(input logic blz);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_sel", 16'(digit_sel_n), 16'hF);
        chk("rst_val", 16'(value_to_display), 16'h0);
        chk("rst_fs", 16'(frame_start), 16'h0);
        load = 1'b1;
        bcd_in = 16'h9999;
        blank_lz = blz;
        repeat (3) @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        e = 0;
        m_pend = 16'd0;
        m_disp = 16'd0;
        m_val = 4'd0;
    endtask

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] r;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 9) == 0)
                r[4*k +: 4] = 4'($urandom_range(10, 15));
            else
                r[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 2) == 0) r = r & 16'h00FF;
        if ($urandom_range(0, 4) == 0) r = 16'd0;
        return r;
    endfunction

    initial begin
        e = 0;
        m_pend = 16'd0;
        m_disp = 16'd0;
        m_val = 4'd0;
        do_reset(1'b0);
        step(1'b1, 16'h1234, 1'b0);
        repeat (40) step(1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 40 && m_dig != 2; i++)
            step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h5678, 1'b0);
        repeat (40) step(1'b0, 16'h0, 1'b0);

        step(1'b1, 16'h0040, 1'b1);
        repeat (30) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0000, 1'b1);
        repeat (30) step(1'b0, 16'h0, 1'b1);

        step(1'b1, 16'h12A4, 1'b0);
        repeat (30) step(1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 40 && (((e + 1 - B) % FR) != 0); i++)
            step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h9876, 1'b0);
        repeat (30) step(1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0), rnd_bcd(),
                 ($urandom_range(0, 1) == 1));
        end

        for (int i = 0; i < 40 && m_dig < 0; i++)
            step(1'b0, 16'h0, 1'b0);
        do_reset(1'b0);
        repeat (30) step(1'b0, 16'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
